// File: rtl/servo_pkg.sv
// Shared servo definitions: position type, timing constants at the 24 MHz
// system clock, and the slew/width helpers used by every servo channel.
// Also imported by the command state machine that produces enable/target.
package servo_pkg;

  typedef logic [7:0] servo_pos_t;

  localparam int unsigned SERVO_CLK_HZ           = 24_000_000;
  localparam int unsigned SERVO_FRAME_CYCLES     = 720_000;  // 30 ms
  localparam int unsigned SERVO_MIN_PULSE_CYCLES = 24_000;   // 1 ms at code 0
  localparam int unsigned SERVO_STEP_CYCLES      = 94;       // code 255 -> ~2 ms
  localparam int unsigned SERVO_SLEW_STEP        = 4;
  localparam int unsigned SERVO_INIT_POS         = 128;

  // Frame counter and pulse width share one 20-bit unsigned domain.
  localparam int unsigned SERVO_CNT_W = 20;
  typedef logic [SERVO_CNT_W-1:0] servo_cnt_t;

  // Move cur toward tgt by at most step codes. Never overshoots, so the
  // result stays inside 0..255 without explicit clamping. step=0 jumps.
  function automatic servo_pos_t servo_step(servo_pos_t cur, servo_pos_t tgt,
                                            int unsigned step);
    int unsigned c, t, d;
    c = {24'd0, cur};
    t = {24'd0, tgt};
    if (step == 0) return tgt;
    if (t >= c) begin
      d = t - c;
      if (d > step) d = step;
      return servo_pos_t'(c + d);
    end
    d = c - t;
    if (d > step) d = step;
    return servo_pos_t'(c - d);
  endfunction

  function automatic servo_cnt_t servo_width(servo_pos_t pos, int unsigned min_cyc,
                                             int unsigned step_cyc);
    int unsigned w;
    w = min_cyc + {24'd0, pos} * step_cyc;
    return servo_cnt_t'(w);
  endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Free-running servo frame counter.
// Ports:
//   clk, reset_n  clock, synchronous active-low reset
//   frame_cnt     counts 0..FRAME_CYCLES-1 and wraps
//   frame_tick    registered strobe, high while frame_cnt == 0 (low in reset)
//   last_cycle    combinational, high while frame_cnt == FRAME_CYCLES-1
module servo_frame_timer
  import servo_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES = SERVO_FRAME_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset_n,
  output logic [SERVO_CNT_W-1:0] frame_cnt,
  output logic                   frame_tick,
  output logic                   last_cycle
);

  localparam servo_cnt_t LAST = servo_cnt_t'(FRAME_CYCLES - 1);

  if (FRAME_CYCLES < 2 || FRAME_CYCLES > (1 << SERVO_CNT_W)) begin : g_bad_frame
    $error("servo_frame_timer: FRAME_CYCLES out of range");
  end

  assign last_cycle = (frame_cnt == LAST);

  // frame_tick is registered from last_cycle so it lines up with cnt==0,
  // except directly after reset where the counter sits at 0 with tick low.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frame_cnt  <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_cnt  <= last_cycle ? '0 : frame_cnt + servo_cnt_t'(1);
      frame_tick <= last_cycle;
    end
  end

endmodule

// File: rtl/servo_slew_driver.sv
// Servo pulse stage for one channel: slew-limited position, one control
// pulse per frame whose width encodes the position.
// Ports:
//   clk, reset_n  clock, synchronous active-low reset
//   enable        1 = drive servo; 0 = pulse off, position frozen
//   target        commanded position code, sampled only at frame boundary
//   servo_pulse   registered control pulse, high for width_q cycles per frame
//   cur_pos       position code currently driven
//   at_target     combinational cur_pos == target
//   frame_tick    one-cycle strobe while the frame counter is 0
module servo_slew_driver
  import servo_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES     = SERVO_FRAME_CYCLES,
  parameter int unsigned MIN_PULSE_CYCLES = SERVO_MIN_PULSE_CYCLES,
  parameter int unsigned STEP_CYCLES      = SERVO_STEP_CYCLES,
  parameter int unsigned SLEW_STEP        = SERVO_SLEW_STEP,
  parameter int unsigned INIT_POS         = SERVO_INIT_POS
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [7:0] target,
  output logic       servo_pulse,
  output logic [7:0] cur_pos,
  output logic       at_target,
  output logic       frame_tick
);

  // The widest pulse must end inside the frame, otherwise the clear
  // compare would never hit and the pulse would run into the next frame.
  if (MIN_PULSE_CYCLES + 255 * STEP_CYCLES >= FRAME_CYCLES) begin : g_bad_width
    $error("servo_slew_driver: max pulse width does not fit in frame");
  end
  if (INIT_POS > 255) begin : g_bad_init
    $error("servo_slew_driver: INIT_POS out of range");
  end

  localparam servo_pos_t INIT_P     = servo_pos_t'(INIT_POS);
  localparam servo_cnt_t INIT_WIDTH = servo_width(INIT_P, MIN_PULSE_CYCLES, STEP_CYCLES);

  servo_cnt_t frame_cnt;
  logic       last_cycle;
  servo_cnt_t width_q;
  logic       armed;
  servo_pos_t next_pos;
  servo_cnt_t next_width;
  logic       pulse_set;
  logic       pulse_hold;

  servo_frame_timer #(
    .FRAME_CYCLES(FRAME_CYCLES)
  ) u_frame_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .frame_cnt (frame_cnt),
    .frame_tick(frame_tick),
    .last_cycle(last_cycle)
  );

  assign next_pos   = servo_step(cur_pos, target, SLEW_STEP);
  assign next_width = servo_width(next_pos, MIN_PULSE_CYCLES, STEP_CYCLES);
  assign at_target  = (cur_pos == target);

  // Position and width only move at the frame boundary, so a target change
  // mid-frame never disturbs the pulse in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cur_pos <= INIT_P;
      width_q <= INIT_WIDTH;
      armed   <= 1'b0;
    end else if (last_cycle) begin
      if (enable) begin
        cur_pos <= next_pos;
        width_q <= next_width;
        armed   <= 1'b1;
      end else begin
        armed   <= 1'b0;
      end
    end
  end

  // The pulse starts on the wrap edge, the same edge that arms the channel
  // and loads the new width, so the first pulse after enable already uses
  // the stepped position. It holds only while enabled, so a pulse cut by
  // enable dropping can never restart until the next wrap.
  assign pulse_set  = last_cycle & enable;
  assign pulse_hold = servo_pulse & enable & armed &
                      ((frame_cnt + servo_cnt_t'(1)) != width_q);

  always_ff @(posedge clk) begin
    if (!reset_n) servo_pulse <= 1'b0;
    else          servo_pulse <= pulse_set | pulse_hold;
  end

endmodule

// File: tb/tb_servo_slew_driver.sv
module tb_servo_slew_driver;

  localparam int FR = 1000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, en0, en_lo;
  logic [7:0] tgt, tgt0, tgt_lo;
  logic       pulse, pulse0, pulse_lo;
  logic [7:0] pos, pos0, pos_lo;
  logic       at_t, at0, at_lo;
  logic       tick, tick0, tick_lo;

  int checks = 0;
  int fails  = 0;
  int w, w0, wlo, tk, first;

  always #5 clk = ~clk;

  // Main channel under test.
  servo_slew_driver #(.FRAME_CYCLES(1000), .MIN_PULSE_CYCLES(100), .STEP_CYCLES(2),
                      .SLEW_STEP(4), .INIT_POS(128)) dut (
    .clk(clk), .reset_n(rst_n), .enable(en), .target(tgt),
    .servo_pulse(pulse), .cur_pos(pos), .at_target(at_t), .frame_tick(tick));

  // No slew limiting: position jumps to target.
  servo_slew_driver #(.FRAME_CYCLES(1000), .MIN_PULSE_CYCLES(100), .STEP_CYCLES(2),
                      .SLEW_STEP(0), .INIT_POS(128)) dut0 (
    .clk(clk), .reset_n(rst_n), .enable(en0), .target(tgt0),
    .servo_pulse(pulse0), .cur_pos(pos0), .at_target(at0), .frame_tick(tick0));

  // Starts at code 2 to exercise the low saturation edge.
  servo_slew_driver #(.FRAME_CYCLES(1000), .MIN_PULSE_CYCLES(100), .STEP_CYCLES(2),
                      .SLEW_STEP(4), .INIT_POS(2)) dut_lo (
    .clk(clk), .reset_n(rst_n), .enable(en_lo), .target(tgt_lo),
    .servo_pulse(pulse_lo), .cur_pos(pos_lo), .at_target(at_lo), .frame_tick(tick_lo));

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
    end
  endtask

  // Starting at a negedge with frame_cnt==0, sample one full frame and end
  // at the negedge where frame_cnt is 0 again. Optionally changes tgt0 at
  // frame_cnt==chg_at.
  task automatic run_frame(input int chg_at, input logic [7:0] chg_val);
    w = 0; w0 = 0; wlo = 0; tk = 0; first = -1;
    for (int i = 0; i < FR; i++) begin
      if (i == chg_at) tgt0 = chg_val;
      if (pulse) begin
        w++;
        if (first < 0) first = i;
      end
      if (pulse0)   w0++;
      if (pulse_lo) wlo++;
      if (tick)     tk++;
      @(negedge clk);
    end
  endtask

  initial begin
    int p, n;
    rst_n = 1'b0; en = 1'b1; tgt = 8'd128;
    en0 = 1'b1; tgt0 = 8'd128; en_lo = 1'b1; tgt_lo = 8'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // reset state (frame_cnt == 0 here)
    chk("rst_pulse", int'(pulse), 0);
    chk("rst_pos", int'(pos), 128);
    chk("rst_tick", int'(tick), 0);
    chk("rst_at", int'(at_t), 1);
    chk("rst_cnt", int'(dut.frame_cnt), 0);
    chk("rst_pos_lo", int'(pos_lo), 2);

    // frame 1: not armed yet
    run_frame(-1, 8'd0);
    chk("f1_w", w, 0);
    chk("f1_tick", tk, 0);
    chk("lo_pos0", int'(pos_lo), 0);

    // frames 2,3: steady 356-cycle pulse
    run_frame(-1, 8'd0);
    chk("f2_w", w, 356);
    chk("f2_first", first, 0);
    chk("f2_tick", tk, 1);
    chk("f2_at", int'(at_t), 1);
    chk("lo_w", wlo, 100);
    run_frame(-1, 8'd0);
    chk("f3_w", w, 356);
    chk("f3_tick", tk, 1);
    chk("lo_nowrap", int'(pos_lo), 0);
    chk("lo_w2", wlo, 100);

    // slew 128 -> 255: +4 per frame, clamp on the 32nd step
    tgt = 8'd255;
    p = 128;
    for (int k = 1; k <= 32; k++) begin
      run_frame(-1, 8'd0);
      chk("slew_w", w, 100 + 2 * p);
      p = (p + 4 > 255) ? 255 : p + 4;
      chk("slew_pos", int'(pos), p);
    end
    chk("slew_end", p, 255);
    run_frame(-1, 8'd0);
    chk("top_w", w, 610);
    chk("top_pos", int'(pos), 255);
    chk("top_at", int'(at_t), 1);

    // enable drops mid-pulse at cnt 50
    repeat (50) @(negedge clk);
    chk("en_pre", int'(pulse), 1);
    en = 1'b0; tgt = 8'd100;
    @(negedge clk);
    chk("en_off", int'(pulse), 0);
    n = 0;
    for (int i = 51; i < FR; i++) begin
      if (pulse) n++;
      @(negedge clk);
    end
    chk("en_rest", n, 0);
    chk("frozen_pos", int'(pos), 255);
    chk("frozen_at", int'(at_t), 0);
    // re-enable at cnt 500: nothing until the next wrap
    n = 0;
    for (int i = 0; i < FR; i++) begin
      if (i == 500) en = 1'b1;
      if (pulse) n++;
      @(negedge clk);
    end
    chk("reen_none", n, 0);
    chk("reen_pos", int'(pos), 251);

    // reset mid-pulse at cnt 200 (width 602)
    repeat (200) @(negedge clk);
    chk("rst_pre", int'(pulse), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst2_pulse", int'(pulse), 0);
    chk("rst2_pos", int'(pos), 128);
    chk("rst2_cnt", int'(dut.frame_cnt), 0);
    chk("rst2_tick", int'(tick), 0);
    rst_n = 1'b1; tgt = 8'd128; tgt0 = 8'd128;

    // SLEW_STEP=0: target 200 written mid-frame at cnt 300
    run_frame(-1, 8'd0);
    chk("s0_f1", w0, 0);
    chk("rst2_f1", w, 0);
    run_frame(300, 8'd200);
    chk("s0_inflight", w0, 356);
    chk("s0_pos", int'(pos0), 200);
    run_frame(-1, 8'd0);
    chk("s0_w", w0, 500);
    chk("s0_at", int'(at0), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
